// File: rtl/io_uart_pkg.sv
// Shared definitions for the serial I/O link: transmitter states and frame geometry.
package io_uart_pkg;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;

    localparam int   DATA_BITS  = 8;
    localparam int   FRAME_BITS = 10;
    localparam logic IDLE_LEVEL = 1'b1;
endpackage

// File: rtl/io_output_fifo.sv
// Transmit byte FIFO: registered storage, occupancy count and full flag.
module io_output_fifo
    import io_uart_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [DATA_BITS-1:0]         push_data,
    input  logic                         pop,
    output logic [DATA_BITS-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]       count,
    output logic                         full,
    output logic                         empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_BITS-1:0] mem_q [DEPTH];
    logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]        count_q, count_d;
    logic                 full_q;
    logic                 do_push, do_pop;

    // Full is judged on the count before this edge, so a write that coincides
    // with a pop while full is still dropped.
    assign do_push = push & ~full_q;
    assign do_pop  = pop & (count_q != '0);
    assign count_d = count_q + CW'(do_push) - CW'(do_pop);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign full     = full_q;
    assign empty    = (count_q == '0);
endmodule

// File: rtl/io_output_controller.sv
// UART-style transmitter: FIFO-buffered bytes sent as start, 8 data bits MSB first, stop.
module io_output_controller
    import io_uart_pkg::*;
#(
    parameter int BIT_PERIOD = 868,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 io_output_trigger,
    input  logic [DATA_BITS-1:0] io_output_value,
    output logic                 RXD,
    output logic                 io_output_full,
    output logic                 io_output_busy,
    output logic                 io_output_overflow
);
    localparam int BCW = $clog2(BIT_PERIOD);
    localparam int ICW = $clog2(DATA_BITS);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [BCW-1:0] BIT_LAST  = BCW'(BIT_PERIOD - 1);
    localparam logic [ICW-1:0] IDX_LAST  = ICW'(DATA_BITS - 1);

    tx_state_t            state_q;
    logic [BCW-1:0]       bit_cnt_q;
    logic [ICW-1:0]       bit_idx_q;
    logic [DATA_BITS-1:0] shift_q;
    logic                 rxd_q, busy_q, overflow_q;

    logic                 fifo_full, fifo_empty, pop;
    logic [DATA_BITS-1:0] fifo_data;
    logic [CW-1:0]        fifo_count;
    logic                 bit_last;

    io_output_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (io_output_trigger),
        .push_data (io_output_value),
        .pop       (pop),
        .pop_data  (fifo_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign bit_last = (bit_cnt_q == BIT_LAST);
    // Head is taken either from idle or at the last stop cycle, so frames chain without a gap.
    assign pop = ~fifo_empty & ((state_q == IDLE) | ((state_q == STOP) & bit_last));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            bit_cnt_q  <= '0;
            bit_idx_q  <= '0;
            shift_q    <= '0;
            rxd_q      <= IDLE_LEVEL;
            busy_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            overflow_q <= io_output_trigger & fifo_full;
            busy_q     <= (state_q != IDLE) | (fifo_count != '0);
            // Line level is registered from the current state, one cycle behind it.
            unique case (state_q)
                IDLE:    rxd_q <= IDLE_LEVEL;
                START:   rxd_q <= 1'b0;
                DATA:    rxd_q <= shift_q[DATA_BITS-1];
                default: rxd_q <= 1'b1;
            endcase

            if (state_q != IDLE) begin
                bit_cnt_q <= bit_last ? '0 : bit_cnt_q + 1'b1;
            end

            unique case (state_q)
                IDLE: begin
                    if (pop) begin
                        state_q   <= START;
                        shift_q   <= fifo_data;
                        bit_cnt_q <= '0;
                        bit_idx_q <= '0;
                    end
                end
                START: begin
                    if (bit_last) state_q <= DATA;
                end
                DATA: begin
                    if (bit_last) begin
                        shift_q <= {shift_q[DATA_BITS-2:0], 1'b0};
                        if (bit_idx_q == IDX_LAST) begin
                            bit_idx_q <= '0;
                            state_q   <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 1'b1;
                        end
                    end
                end
                default: begin
                    if (bit_last) begin
                        if (pop) begin
                            state_q <= START;
                            shift_q <= fifo_data;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
            endcase
        end
    end

    assign RXD                = rxd_q;
    assign io_output_full     = fifo_full;
    assign io_output_busy     = busy_q;
    assign io_output_overflow = overflow_q;
endmodule
